// File: rtl/pipelined_carry_increment_adder_if.sv
// Stream bundle for the pipelined carry-increment adder/subtractor.
// The master drives operands and downstream ready; the slave returns the result.
interface pipelined_carry_increment_adder_if #(
    parameter int unsigned N = 32
);
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         cin;
    logic         sub;
    logic         inValid;
    logic         inReady;
    logic [N-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         outValid;
    logic         outReady;

    modport master (
        output in1, in2, cin, sub, inValid, outReady,
        input  inReady, sum, cout, overflow, outValid
    );

    modport slave (
        input  in1, in2, cin, sub, inValid, outReady,
        output inReady, sum, cout, overflow, outValid
    );
endinterface

// File: rtl/pipelined_carry_increment_adder.sv
// Two-stage carry-increment adder/subtractor: stage 1 ripples K independent blocks,
// stage 2 resolves inter-block carries by incrementing blocks and registers the result.
module pipelined_carry_increment_adder #(
    parameter int unsigned N     = 32,
    parameter int unsigned BLOCK = 8
) (
    input logic clk,
    input logic rst_n,
    pipelined_carry_increment_adder_if.slave bus
);
    localparam int unsigned K  = N / BLOCK;
    localparam int unsigned BW = BLOCK + 1;

    typedef struct packed {
        logic [N-1:0] s;      // per-block ripple sums
        logic [K-1:0] g;      // per-block carry out
        logic [K-1:0] p;      // per-block sum is all ones
        logic         a_msb;
        logic         b_msb;
    } stage1_t;

    if ((N % BLOCK) != 0 || BLOCK < 2) begin : g_bad_cfg
        $error("N must be a multiple of BLOCK and BLOCK must be at least 2");
    end

    logic [N-1:0] b_eff;
    logic         c0;
    stage1_t      s1_d;
    stage1_t      s1_q;
    logic         s1_valid;
    logic         out_valid;
    logic         in_ready;
    logic         s1_load;
    logic         s2_load;
    logic [K:0]   k;
    logic [N-1:0] sum_d;
    logic         ovf_d;
    logic [N-1:0] sum_q;
    logic         cout_q;
    logic         ovf_q;

    // Stage 1: independent ripple per block; only block 0 sees the real carry-in
    always_comb begin
        logic [BLOCK:0] blk;
        blk   = '0;
        s1_d  = '0;
        b_eff = bus.sub ? ~bus.in2 : bus.in2;
        c0    = bus.sub | bus.cin;
        for (int i = 0; i < int'(K); i++) begin
            blk = BW'(bus.in1[i*BLOCK +: BLOCK]) + BW'(b_eff[i*BLOCK +: BLOCK])
                + BW'((i == 0) ? c0 : 1'b0);
            s1_d.s[i*BLOCK +: BLOCK] = blk[BLOCK-1:0];
            s1_d.g[i]                = blk[BLOCK];
            s1_d.p[i]                = &blk[BLOCK-1:0];
        end
        s1_d.a_msb = bus.in1[N-1];
        s1_d.b_msb = b_eff[N-1];
    end

    // Stage 2: carry into block 0 is zero, so block 0 passes through unchanged
    always_comb begin
        k     = '0;
        sum_d = '0;
        for (int i = 0; i < int'(K); i++) begin
            sum_d[i*BLOCK +: BLOCK] = s1_q.s[i*BLOCK +: BLOCK] + BLOCK'(k[i]);
            k[i+1]                  = s1_q.g[i] | (s1_q.p[i] & k[i]);
        end
        ovf_d = (s1_q.a_msb == s1_q.b_msb) & (sum_d[N-1] != s1_q.a_msb);
    end

    assign s2_load  = s1_valid & (~out_valid | bus.outReady);
    assign in_ready = ~s1_valid | ~out_valid | bus.outReady;
    assign s1_load  = bus.inValid & in_ready;

    // Stage-1 payload is not reset; s1_valid qualifies it
    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_q <= s1_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                out_valid <= 1'b1;
                sum_q     <= sum_d;
                cout_q    <= k[K];
                ovf_q     <= ovf_d;
            end else if (bus.outReady) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.inReady  = in_ready;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
    assign bus.outValid = out_valid;
endmodule
